// File: rtl/alu_pkg.sv
// Shared types for the tinyalu command front end: opcodes, queued command
// format and the sequencer state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } op_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    op_e        op;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DONE,
    ST_PULSE,
    ST_RESP
  } seq_state_e;

  // Ops the ALU answers with a done pulse.
  function automatic logic is_legal(op_e op);
    return op inside {add_op, and_op, xor_op, mul_op};
  endfunction

  // Ops that get a single-cycle start and no done.
  function automatic logic is_pulse(op_e op);
    return op inside {no_op, rst_op};
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), registered count, no
// same-cycle bypass from push to pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  cmd_t                         data_i,
  input  logic                         pop_i,
  output cmd_t                         data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front end for tinyalu: queues commands, drives the start/done handshake one
// command at a time and returns one in-order response per accepted command.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  op,
  output logic        start,
  input  logic        done,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT);

  cmd_t             fifo_wdata, fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CNT_W-1:0] fifo_count;

  seq_state_e       state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  op_e              op_q, op_d;
  logic             start_q, start_d;
  logic [15:0]      res_q, res_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Held low while in reset so nothing is accepted before reset releases.
  assign cmd_ready  = reset_n & ~fifo_full;
  assign fifo_push  = cmd_valid & cmd_ready;
  assign fifo_wdata = '{a: cmd_a, b: cmd_b, op: op_e'(cmd_op)};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= no_op;
      start_q <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
      res_q   <= res_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    start_d  = start_q;
    res_d    = res_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          a_d      = fifo_head.a;
          b_d      = fifo_head.b;
          op_d     = fifo_head.op;
          tmo_d    = '0;
          if (is_legal(fifo_head.op)) begin
            start_d = 1'b1;
            state_d = ST_WAIT_DONE;
          end else if (is_pulse(fifo_head.op)) begin
            start_d = 1'b1;
            state_d = ST_PULSE;
          end else begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT_DONE: begin
        // done wins over a timeout landing on the same edge.
        if (done) begin
          res_d   = result;
          err_d   = 1'b0;
          start_d = 1'b0;
          state_d = ST_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_PULSE: begin
        start_d = 1'b0;
        res_d   = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign A          = a_q;
  assign B          = b_q;
  assign op         = op_q;
  assign start      = start_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = res_q;
  assign rsp_op     = op_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural tinyalu responder.
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk, reset_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start, done;
  logic [15:0] result;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err, busy;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic done_en = 1'b1;
  int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int   alu_lat = 1;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .A(A), .B(B), .op(op), .start(start), .done(done), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] alu_compute(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] o);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] o, input logic den);
    exp_t e;
    e.a = a; e.b = b; e.op = o; e.res = 16'h0; e.err = 1'b0;
    if (o inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
      if (den) e.res = alu_compute(a, b, o);
      else     e.err = 1'b1;
    end else if (o inside {3'd5, 3'd6}) begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      cmd_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    if (cmd_ready) begin
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = o;
      exp_q.push_back(model(a, b, o, done_en));
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 1'b0);
  endtask

  // Response monitor: compares every presented response with the queue head
  // and chooses rsp_ready for the coming edge.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rsp_ready = 1'b0;
      end else begin
        if (rsp_valid) begin
          chk("rsp_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0)
            chk("rsp", {rsp_result, rsp_op, rsp_err},
                {exp_q[0].res, exp_q[0].op, exp_q[0].err});
        end
        case (rdy_mode)
          0:       rsp_ready = 1'b0;
          1:       rsp_ready = 1'b1;
          default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
        if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // Behavioural ALU: answers legal ops with done after 1..4 cycles of start.
  initial begin
    done   = 1'b0;
    result = 16'h0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (reset_n && start && done_en && (op inside {3'd1, 3'd2, 3'd3, 3'd4})) begin
        alu_lat = $urandom_range(1, 4);
        repeat (alu_lat - 1) @(negedge clk);
        if (exp_q.size() > 0)
          chk("alu_operands", {A, B, op}, {exp_q[0].a, exp_q[0].b, exp_q[0].op});
        result = alu_compute(A, B, op);
        done   = 1'b1;
      end
    end
  end

  // start pulse watcher: operands at issue and exact high time.
  initial begin
    int         len = 0;
    logic [2:0] sop = 3'd0;
    int         req;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        len = 0;
      end else if (start) begin
        if (len == 0) begin
          sop = op;
          chk("start_on_illegal", (sop == 3'd5 || sop == 3'd6), 1'b0);
          if (exp_q.size() > 0)
            chk("issue_cmd", {A, B, op}, {exp_q[0].a, exp_q[0].b, exp_q[0].op});
        end
        len++;
      end else if (len != 0) begin
        if (sop == 3'd0 || sop == 3'd7) req = 1;
        else if (!done_en)              req = TIMEOUT;
        else                            req = alu_lat;
        chk("start_len", len, req);
        len = 0;
      end
    end
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {A, B, op, start, rsp_valid, rsp_result, rsp_op, rsp_err, busy}, '0);
    chk("reset_cmd_ready_low", cmd_ready, 1'b0);
    reset_n = 1'b1;
    #1 chk("reset_cmd_ready_high", cmd_ready, 1'b1);
    @(negedge clk);

    send(8'hFF, 8'h01, 3'd1);
    drain();
    send(8'hFF, 8'hFF, 3'd4);
    send(8'hAA, 8'h55, 3'd3);
    drain();

    // Back-pressure: one command in flight, four queued, sixth refused.
    rdy_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      send(8'($urandom), 8'($urandom), 3'($urandom_range(1, 4)));
    chk("full_cmd_ready", cmd_ready, 1'b0);
    repeat (8) @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_busy", busy, 1'b1);
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    send(8'($urandom), 8'($urandom), 3'($urandom_range(1, 4)));
    drain();

    // Timeout, then normal recovery.
    done_en = 1'b0;
    send(8'h12, 8'h34, 3'd1);
    drain();
    done_en = 1'b1;
    send(8'h12, 8'h34, 3'd1);
    drain();

    // Illegal and pulse-only opcodes.
    send(8'h11, 8'h22, 3'd5);
    send(8'h33, 8'h44, 3'd6);
    send(8'h55, 8'h66, 3'd0);
    send(8'h77, 8'h88, 3'd7);
    drain();

    // Reset during WAIT_DONE with two commands queued.
    done_en = 1'b0;
    send(8'h01, 8'h02, 3'd2);
    send(8'h03, 8'h04, 3'd2);
    send(8'h05, 8'h06, 3'd2);
    repeat (2) @(negedge clk);
    chk("pre_reset_start", start, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_start", start, 1'b0);
    chk("mid_reset_rsp_valid", rsp_valid, 1'b0);
    chk("mid_reset_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    done_en = 1'b1;
    #1 chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    repeat (30) @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    send(8'h80, 8'h80, 3'd1);
    drain();

    // Randomised traffic with random back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the tinyalu core: buffers operand/opcode commands from a valid/ready stream in a small FIFO and issues them one at a time using the ALU start/done protocol.
- Returns exactly one response per accepted command, in order, on a valid/ready result stream.
- Replaces direct pin-wiggling of A/B/op/start from the test environment with a synthesizable front end.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 64, maximum cycles start is held waiting for done before abort (≥2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  opcode
- A  out  8  to ALU
- B  out  8  to ALU
- op  out  3  to ALU
- start  out  1  to ALU
- done  in  1  from ALU, single-cycle pulse
- result  in  16  from ALU
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  16  result
- rsp_op  out  3  opcode of the completed command
- rsp_err  out  1  1 = timeout or illegal opcode
- busy  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset: asynchronous on reset_n low. FIFO flushed; FSM to IDLE. All outputs 0 (A, B, op, start, rsp_*, busy), except cmd_ready = 1 once reset_n is high. Reset mid-operation drops start immediately; any in-flight command is lost.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = (count < DEPTH), from registered count; no same-cycle pop bypass.
  - Simultaneous push and pop allowed when not full; count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT_DONE, PULSE, RESP.
- IDLE:
  - If FIFO non-empty: pop head and register A/B/op.
  - Legal ALU op (add, and, xor, mul): start = 1, go WAIT_DONE.
  - no_op or rst_op: start = 1, go PULSE.
  - Illegal op (3'b101, 3'b110): start stays 0; load rsp_result = 0, rsp_err = 1; go RESP.
  - start rises in the cycle after the acceptance edge when the FIFO was empty and the FSM idle.
- PULSE: start = 0, rsp_result = 0, rsp_err = 0, go RESP. start is high exactly one cycle.
- WAIT_DONE:
  - start held 1; A/B/op held stable; timeout counter increments each cycle.
  - On the edge sampling done = 1: capture result into rsp_result, rsp_err = 0, start = 0, go RESP.
  - If counter reaches TIMEOUT without done: start = 0, rsp_result = 0, rsp_err = 1, go RESP. start has then been high exactly TIMEOUT cycles.
  - done sampled in any other state is ignored.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_op and rsp_err stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid = 0, go IDLE. The next command issues on the following edge; minimum one idle cycle between commands.
  - The FIFO continues accepting commands while back-pressured.
- Widths: no arithmetic in this block; result passes through unmodified. rsp_op mirrors the issued op.
- A/B/op keep their last values outside WAIT_DONE/PULSE. They are don't-care to the ALU but deterministic.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] op_e: no_op = 3'b000, add_op = 3'b001, and_op = 3'b010, xor_op = 3'b011, mul_op = 3'b100, rst_op = 3'b111.
  - function is_legal(op_e).
  - typedef struct packed cmd_t {a, b, op}.
  - FSM state enum.
- Sub-module: alu_cmd_fifo (parameter DEPTH; cmd_t data; push/pop/full/empty/count). The sequencer holds only the FSM, timeout counter and response registers.

Test Plan:
- add A = 8'hFF, B = 8'h01 → start high until done, rsp_result = 16'h0100, rsp_err = 0, rsp_op = 3'b001.
- mul A = 8'hFF, B = 8'hFF → rsp_result = 16'hFE01; then xor 8'hAA/8'h55 → 16'h00FF; responses in order.
- rsp_ready held 0, DEPTH = 4, push 6 commands back-to-back:
  - One command is issued; 4 are queued; cmd_ready = 0 on the sixth.
  - The response is held stable.
  - Release rsp_ready: all 6 responses arrive in push order.
- done tied 0, TIMEOUT = 16, add command → start high exactly 16 cycles, then rsp_err = 1, rsp_result = 0; the next command is processed normally.
- cmd_op = 3'b101 → start never asserted, rsp_err = 1; no_op → start high 1 cycle, rsp_result = 0, rsp_err = 0.
- reset_n pulsed low during WAIT_DONE with 2 queued → start, rsp_valid and busy 0 immediately; cmd_ready = 1 after release; no stale responses.
